serial_add_unit: RTL
====================

SERIAL_ADD_UNIT -- requirements
Module: serial_add_unit

Interface
REQ-001 The block SHALL have parameter W, default 8, giving operand/result width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 a  input  W  operand A, unsigned (signed when overflow feature compiled in).
REQ-006 b  input  W  operand B.
REQ-007 busy  output  1  high while bit-serial addition is in progress.
REQ-008 done  output  1  one-cycle pulse marking a new valid result.
REQ-009 sum  output  W  registered result of the last completed addition.
REQ-010 carry  output  1  registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT, DONE; IDLE is the reset state.
REQ-012 IDLE, start=1 at an edge: latch a and b into shift registers, clear internal carry flop, clear bit counter, go to SHIFT.
REQ-013 IDLE, start=0: remain in IDLE; no register other than state changes.
REQ-014 SHIFT, each edge: compute one result bit, LSB first, as a full adder built from two half adders (bit = a0^b0^c; c_next = a0&b0 | c&(a0^b0)); shift the bit into the partial-sum register from the MSB side; shift both operand registers right by one; increment counter.
REQ-015 SHIFT SHALL last exactly W edges; on the W-th edge go to DONE, copying the partial sum to sum and the final carry to carry.
REQ-016 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-017 done SHALL be high only in DONE, so it rises W edges after the edge that accepted start; busy SHALL be high only in SHIFT.
REQ-018 start asserted in SHIFT or DONE SHALL be ignored, not queued; the next request is accepted only once the FSM is back in IDLE.
REQ-019 Changes on a or b after acceptance SHALL NOT affect the result in progress.
REQ-020 sum and carry SHALL hold their previous values throughout SHIFT and change only on the edge entering DONE.
REQ-021 The result SHALL equal (a+b) mod 2^W, with carry = bit W of a+b.
REQ-022 Back-to-back requests: start held high continuously SHALL yield one result every W+2 cycles.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, sum=0, carry=0, internal carry=0, counter=0, operand and partial registers=0, independent of clk.
REQ-024 Reset during SHIFT SHALL abandon the operation with no done pulse, and sum/carry SHALL read 0.
REQ-025 The first edge after rst_n deasserts SHALL be able to accept start.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN defined: add output ovf (1 bit), registered with sum, equal to signed two's-complement overflow (carry into MSB XOR carry out of MSB); reset value 0.
REQ-027 Macro SERIAL_ADD_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 W=8, a=0x00, b=0x00, start pulse -> done after 8 edges, sum=0x00, carry=0, busy high for exactly 8 cycles.
REQ-029 W=8, a=0xFF, b=0x01 -> sum=0x00, carry=1; a=0xA5, b=0x5A -> sum=0xFF, carry=0.
REQ-030 Start pulsed again 3 cycles into SHIFT with a=0x10, b=0x10 -> ignored; a single done is produced, carrying the original result.
REQ-031 rst_n driven low at SHIFT cycle 4 -> all outputs 0 at once, no done; a fresh start after release gives a correct result.
REQ-032 SERIAL_ADD_OVF_EN defined, a=0x7F, b=0x01 -> sum=0x80, carry=0, ovf=1; a=0xFF, b=0x01 -> ovf=0, carry=1.
REQ-033 Exhaustive W=4 sweep of all 256 operand pairs with start held high -> every result matches a+b, one result every 6 cycles.

Source files
------------

// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial W-bit adder producing one result bit per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to add a registered signed-overflow output (ovf).

module serial_add_unit #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         carry
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  psum_q, psum_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          c_q, c_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    logic last;
    logic hs1, hc1, hc2;
    logic bit_s, c_next;

    assign last = (cnt_q == CW'(W - 1));

    // Full adder built from two half adders on the operand LSBs.
    assign hs1    = opa_q[0] ^ opb_q[0];
    assign hc1    = opa_q[0] & opb_q[0];
    assign bit_s  = hs1 ^ c_q;
    assign hc2    = hs1 & c_q;
    assign c_next = hc1 | hc2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    opa_d = a;
                    opb_d = b;
                    c_d   = 1'b0;
                    cnt_d = '0;
                end
            end
            StShift: begin
                psum_d = {bit_s, psum_q[W-1:1]};
                opa_d  = {1'b0, opa_q[W-1:1]};
                opb_d  = {1'b0, opb_q[W-1:1]};
                c_d    = c_next;
                cnt_d  = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = {bit_s, psum_q[W-1:1]};
                    carry_d = c_next;
`ifdef SERIAL_ADD_OVF_EN
                    // c_q is the carry into the MSB on the final step.
                    ovf_d   = c_q ^ c_next;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule
